// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode queue interface.
// Groups the IF2 push side, the issue pop count, the flush and the decode view.
//   master : driven by the fetch/issue side (inputs of the queue), reads the view.
//   slave  : the queue itself.
// Signals:
//   i_flush                     synchronous queue clear
//   i_PC1/i_IR1, i_PC2/i_IR2    older / younger incoming {PC, IR}
//   i_is_valid                  [1] slot1 valid, [0] slot2 valid
//   i_pop_num                   entries consumed this cycle (3 behaves as 2)
//   o_PC1/o_IR1, o_PC2/o_IR2    head / head+1 entry, zero when not valid
//   o_is_valid                  [1] head valid, [0] head+1 valid
//   o_is_full                   fewer than two free entries
//   o_count                     occupancy
interface inst_fetch_queue_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             i_flush;
    logic [31:0]      i_PC1;
    logic [31:0]      i_IR1;
    logic [31:0]      i_PC2;
    logic [31:0]      i_IR2;
    logic [1:0]       i_is_valid;
    logic [1:0]       i_pop_num;
    logic [31:0]      o_PC1;
    logic [31:0]      o_IR1;
    logic [31:0]      o_PC2;
    logic [31:0]      o_IR2;
    logic [1:0]       o_is_valid;
    logic             o_is_full;
    logic [PTR_W:0]   o_count;

    modport master (
        output i_flush, i_PC1, i_IR1, i_PC2, i_IR2, i_is_valid, i_pop_num,
        input  o_PC1, o_IR1, o_PC2, o_IR2, o_is_valid, o_is_full, o_count
    );

    modport slave (
        input  i_flush, i_PC1, i_IR1, i_PC2, i_IR2, i_is_valid, i_pop_num,
        output o_PC1, o_IR1, o_PC2, o_IR2, o_is_valid, o_is_full, o_count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue between IF2 and the two ID decoders.
// Circular buffer of DEPTH {PC, IR} entries; accepts up to two pairs per cycle,
// presents the oldest two, drains up to two per cycle, cleared by i_flush.
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset (pointers and count only; storage is not reset)
//   ifq   inst_fetch_queue_if.slave (push, pop, flush and decode view)
// Build option:
//   IFQ_BYPASS_EN  when defined, an empty queue forwards incoming slots straight to the
//                  decode view in the same cycle; consumed bypassed slots are never stored.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input logic                 clk,
    input logic                 rstn,
    inst_fetch_queue_if.slave   ifq
);
    localparam int unsigned    PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0] CntOne    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] CntTwo    = (PTR_W + 1)'(2);
    localparam logic [PTR_W:0] FullLimit = (PTR_W + 1)'(DEPTH - 2);

    logic [31:0]      pc_mem [DEPTH];
    logic [31:0]      ir_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             full, bypass, push_acc;
    logic [1:0]       in_n, pop_req, avail, pop_eff, skip, head_adv, push_eff;
    logic [31:0]      c0_pc, c0_ir, c1_pc, c1_ir, wr0_pc, wr0_ir;
    logic             wr0_en, wr1_en;
    logic             v1, v2;
    logic [31:0]      pc1, ir1, pc2, ir2;
    logic [PTR_W-1:0] head_p1, tail_p1;

    assign head_p1 = head_q + 1'b1;
    assign tail_p1 = tail_q + 1'b1;

    always_comb begin
        in_n    = {1'b0, ifq.i_is_valid[1]} + {1'b0, ifq.i_is_valid[0]};
        // Compacted incoming list: slot2 moves up when slot1 is empty.
        c0_pc   = ifq.i_is_valid[1] ? ifq.i_PC1 : ifq.i_PC2;
        c0_ir   = ifq.i_is_valid[1] ? ifq.i_IR1 : ifq.i_IR2;
        c1_pc   = ifq.i_PC2;
        c1_ir   = ifq.i_IR2;

        pop_req = (ifq.i_pop_num == 2'd3) ? 2'd2 : ifq.i_pop_num;
        full    = count_q > FullLimit;
`ifdef IFQ_BYPASS_EN
        bypass  = (count_q == '0) && !ifq.i_flush;
`else
        bypass  = 1'b0;
`endif
        if (bypass) begin
            avail = in_n;
        end else if (count_q >= CntTwo) begin
            avail = 2'd2;
        end else begin
            avail = {1'b0, count_q[0]};
        end
        pop_eff  = (pop_req < avail) ? pop_req : avail;

        // Bypassed slots that are consumed never reach storage; stored entries pop via head.
        skip     = bypass ? pop_eff : 2'd0;
        head_adv = bypass ? 2'd0 : pop_eff;
        push_acc = !full && !ifq.i_flush;
        push_eff = push_acc ? (in_n - skip) : 2'd0;

        wr0_pc   = (skip == 2'd0) ? c0_pc : c1_pc;
        wr0_ir   = (skip == 2'd0) ? c0_ir : c1_ir;
        wr0_en   = push_eff != 2'd0;
        wr1_en   = push_eff == 2'd2;

        if (ifq.i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(head_adv);
            tail_d  = tail_q + PTR_W'(push_eff);
            count_d = count_q - (PTR_W + 1)'(head_adv) + (PTR_W + 1)'(push_eff);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            pc_mem[tail_q] <= wr0_pc;
            ir_mem[tail_q] <= wr0_ir;
        end
        if (wr1_en) begin
            pc_mem[tail_p1] <= c1_pc;
            ir_mem[tail_p1] <= c1_ir;
        end
    end

    always_comb begin
        if (bypass) begin
            v1  = in_n != 2'd0;
            v2  = in_n == 2'd2;
            pc1 = c0_pc;
            ir1 = c0_ir;
            pc2 = c1_pc;
            ir2 = c1_ir;
        end else begin
            v1  = count_q >= CntOne;
            v2  = count_q >= CntTwo;
            pc1 = pc_mem[head_q];
            ir1 = ir_mem[head_q];
            pc2 = pc_mem[head_p1];
            ir2 = ir_mem[head_p1];
        end
        ifq.o_is_valid = {v1, v2};
        ifq.o_PC1      = v1 ? pc1 : 32'h0;
        ifq.o_IR1      = v1 ? ir1 : 32'h0;
        ifq.o_PC2      = v2 ? pc2 : 32'h0;
        ifq.o_IR2      = v2 ? ir2 : 32'h0;
        ifq.o_is_full  = full;
        ifq.o_count    = count_q;
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned VW    = 2 + 4 * 32 + PTR_W + 1 + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] mq[$];

    always #5 clk = ~clk;

    inst_fetch_queue_if #(.DEPTH(DEPTH)) ifc ();

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .ifq  (ifc.slave)
    );

    function automatic logic [VW-1:0] dut_view();
        return {ifc.o_is_valid, ifc.o_PC1, ifc.o_IR1, ifc.o_PC2, ifc.o_IR2,
                ifc.o_count, ifc.o_is_full};
    endfunction

    // Expected decode view from the reference queue contents.
    function automatic logic [VW-1:0] model_view();
        int          sz;
        logic [63:0] e0, e1;
        sz = mq.size();
        e0 = (sz >= 1) ? mq[0] : 64'h0;
        e1 = (sz >= 2) ? mq[1] : 64'h0;
        return {sz >= 1, sz >= 2, e0, e1, (PTR_W + 1)'(sz), (DEPTH - sz) < 2};
    endfunction

    // Drive one cycle of stimulus and advance the reference queue at the clock edge.
    task automatic step(input logic fl, input logic [1:0] v, input logic [1:0] pop,
                        input logic [31:0] p1, input logic [31:0] i1,
                        input logic [31:0] p2, input logic [31:0] i2);
        int sz, pe, av;
        bit was_full;
        @(negedge clk);
        ifc.i_flush    = fl;
        ifc.i_is_valid = v;
        ifc.i_pop_num  = pop;
        ifc.i_PC1      = p1;
        ifc.i_IR1      = i1;
        ifc.i_PC2      = p2;
        ifc.i_IR2      = i2;
        @(posedge clk);
        sz = mq.size();
        was_full = (DEPTH - sz) < 2;
        if (fl) begin
            mq.delete();
        end else begin
            pe = (pop == 2'd3) ? 2 : int'(pop);
            av = (sz < 2) ? sz : 2;
            if (pe > av) pe = av;
            repeat (pe) void'(mq.pop_front());
            if (!was_full) begin
                if (v[1]) mq.push_back({p1, i1});
                if (v[0]) mq.push_back({p2, i2});
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic flush_q();
        step(1'b1, 2'b00, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        ifc.i_flush = 1'b0; ifc.i_is_valid = 2'b00; ifc.i_pop_num = 2'd0;
        ifc.i_PC1 = '0; ifc.i_IR1 = '0; ifc.i_PC2 = '0; ifc.i_IR2 = '0;
        rstn = 1'b0;
        #12;
        checks++;
        if (dut_view() !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", dut_view(), {VW{1'b0}});
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] pc;
        for (int k = 0; k < 5; k++) begin
            pc = 32'h1c00_0000 + 32'(k * 8);
            step(1'b0, 2'b11, 2'd0, pc, ~pc, pc + 32'h4, ~(pc + 32'h4));
            #1;
            checks++;
            if (dut_view() !== model_view()) begin
                failures++;
                $display("FAIL fill_%0d: got %h want %h", k, dut_view(), model_view());
            end
        end
        checks++;
        if ({ifc.o_count, ifc.o_is_full, ifc.o_PC1, ifc.o_PC2} !==
            {4'd8, 1'b1, 32'h1c00_0000, 32'h1c00_0004}) begin
            failures++;
            $display("FAIL fill_full: got cnt=%0d full=%b pc1=%h pc2=%h want 8 1 1c000000 1c000004",
                     ifc.o_count, ifc.o_is_full, ifc.o_PC1, ifc.o_PC2);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        flush_q();
        pc = 32'h2000_0000;
        step(1'b0, 2'b11, 2'd0, pc, ~pc, pc + 32'h4, ~(pc + 32'h4));
        for (int k = 1; k <= 20; k++) begin
            pc = 32'h2000_0000 + 32'(k * 8);
            step(1'b0, 2'b11, 2'd2, pc, ~pc, pc + 32'h4, ~(pc + 32'h4));
            #1;
            checks++;
            if (ifc.o_PC1 !== pc || ifc.o_count !== 4'd2) begin
                failures++;
                $display("FAIL stream_%0d: got pc1=%h cnt=%0d want pc1=%h cnt=2",
                         k, ifc.o_PC1, ifc.o_count, pc);
            end
            checks++;
            if (dut_view() !== model_view()) begin
                failures++;
                $display("FAIL stream_view_%0d: got %h want %h", k, dut_view(), model_view());
            end
        end
    endtask

    task automatic test_slot2_only();
        flush_q();
        step(1'b0, 2'b01, 2'd0, 32'hdead_beef, 32'h1, 32'h1c00_0014, 32'h0000_0013);
        #1;
        checks++;
        if ({ifc.o_is_valid, ifc.o_PC1, ifc.o_IR1, ifc.o_count} !==
            {2'b10, 32'h1c00_0014, 32'h0000_0013, 4'd1}) begin
            failures++;
            $display("FAIL slot2_only: got v=%b pc1=%h ir1=%h cnt=%0d want 10 1c000014 00000013 1",
                     ifc.o_is_valid, ifc.o_PC1, ifc.o_IR1, ifc.o_count);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 2'b00, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if ({ifc.o_is_valid, ifc.o_count, ifc.o_PC1} !== {2'b00, 4'd0, 32'h0}) begin
            failures++;
            $display("FAIL underflow: got v=%b cnt=%0d pc1=%h want 00 0 0",
                     ifc.o_is_valid, ifc.o_count, ifc.o_PC1);
        end
        step(1'b0, 2'b00, 2'd3, 32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (dut_view() !== '0) begin
            failures++;
            $display("FAIL underflow_hold: got %h want 0", dut_view());
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++)
            step(1'b0, 2'b11, 2'd0, 32'h300 + 32'(k * 8), 32'h7, 32'h304 + 32'(k * 8), 32'h8);
        #1;
        checks++;
        if (ifc.o_count !== 4'd6) begin
            failures++;
            $display("FAIL flush_pre: got cnt=%0d want 6", ifc.o_count);
        end
        step(1'b1, 2'b11, 2'd2, 32'h400, 32'h1, 32'h404, 32'h2);
        #1;
        checks++;
        if ({ifc.o_is_valid, ifc.o_count} !== {2'b00, 4'd0}) begin
            failures++;
            $display("FAIL flush_clear: got v=%b cnt=%0d want 00 0", ifc.o_is_valid, ifc.o_count);
        end
        step(1'b0, 2'b11, 2'd0, 32'h500, 32'h5, 32'h504, 32'h6);
        #1;
        checks++;
        if ({ifc.o_is_valid, ifc.o_PC1, ifc.o_PC2, ifc.o_count} !==
            {2'b11, 32'h500, 32'h504, 4'd2}) begin
            failures++;
            $display("FAIL flush_after: got v=%b pc1=%h pc2=%h cnt=%0d want 11 500 504 2",
                     ifc.o_is_valid, ifc.o_PC1, ifc.o_PC2, ifc.o_count);
        end
    endtask

    task automatic test_reset_mid();
        flush_q();
        for (int k = 0; k < 3; k++)
            step(1'b0, (k == 2) ? 2'b10 : 2'b11, 2'd0, 32'h600 + 32'(k * 8), 32'h1,
                 32'h604 + 32'(k * 8), 32'h2);
        #1;
        checks++;
        if (ifc.o_count !== 4'd5) begin
            failures++;
            $display("FAIL rst_mid_pre: got cnt=%0d want 5", ifc.o_count);
        end
        #1;
        rstn = 1'b0;
        mq.delete();
        #1;
        checks++;
        if ({ifc.o_is_valid, ifc.o_is_full, ifc.o_count} !== {2'b00, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL rst_mid: got v=%b full=%b cnt=%0d want 00 0 0",
                     ifc.o_is_valid, ifc.o_is_full, ifc.o_count);
        end
        #1;
        rstn = 1'b1;
        step(1'b0, 2'b11, 2'd0, 32'h700, 32'h9, 32'h704, 32'ha);
        #1;
        checks++;
        if (dut_view() !== model_view()) begin
            failures++;
            $display("FAIL rst_mid_push: got %h want %h", dut_view(), model_view());
        end
    endtask

    task automatic test_random();
        logic [1:0] v, pop;
        logic       fl;
        for (int k = 0; k < 400; k++) begin
            fl  = ($urandom_range(0, 19) == 0);
            v   = 2'($urandom);
            pop = 2'($urandom);
            step(fl, v, pop, $urandom, $urandom, $urandom, $urandom);
            #1;
            checks++;
            if (dut_view() !== model_view()) begin
                failures++;
                $display("FAIL random_%0d: got %h want %h", k, dut_view(), model_view());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_slot2_only();
        test_underflow();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
